alu_seq_n_bits: RTL and testbench

// Parametrised, registered successor to the combinational N-bit ALU.
// - Same 4-bit op map (0 add .. 9 div).
// - Adds a valid/ready handshake, registered result and flags, and a
//   2N-bit product.
// - MUL, DIV and MOD are iterative (one bit per cycle) instead of

---
 rtl/alu_seq_n_bits.sv | 189 ++++++++++++++++++
 tb/tb_alu_seq_n_bits.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_n_bits.sv
// Registered N-bit ALU with valid/ready handshake. Single-cycle ops finish at
// the accept edge; mul/div/mod iterate one bit per cycle.
module alu_seq_n_bits #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   control,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic         v,
  output logic         c,
  output logic         n,
  output logic         z,
  output logic         err
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_LSR = 4'd5;
  localparam logic [3:0] OP_LSL = 4'd6;
  localparam logic [3:0] OP_MOD = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;

  logic [1:0]    state;
  logic [3:0]    op_reg;
  logic [N-1:0]  b_reg;
  logic [N-1:0]  acc;
  logic [N-1:0]  q;
  logic [CW-1:0] cnt;

  logic [N-1:0] b_op;
  logic [N:0]   sum_ext;
  logic [N-1:0] s_res;
  logic         s_c;
  logic         s_v;
  logic         s_err;
  logic         is_sub;
  logic         long_op;

  logic [N:0]   mul_sum;
  logic [N:0]   div_trial;
  logic [N-1:0] acc_nxt;
  logic [N-1:0] q_nxt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Single-cycle result, computed straight from the live inputs at accept.
  always_comb begin
    is_sub  = (control == OP_SUB);
    b_op    = is_sub ? ~b : b;
    sum_ext = {1'b0, a} + {1'b0, b_op} + {{N{1'b0}}, is_sub};
    s_res   = '0;
    s_c     = 1'b0;
    s_v     = 1'b0;
    s_err   = 1'b0;
    long_op = 1'b0;
    case (control)
      OP_ADD, OP_SUB: begin
        s_res = sum_ext[N-1:0];
        s_c   = sum_ext[N];
        s_v   = (a[N-1] == b_op[N-1]) && (sum_ext[N-1] != a[N-1]);
      end
      OP_AND: s_res = a & b;
      OP_OR:  s_res = a | b;
      OP_XOR: s_res = a ^ b;
      OP_LSR: s_res = a >> b;
      OP_LSL: s_res = a << b;
      OP_MUL: long_op = 1'b1;
      OP_DIV, OP_MOD: begin
        long_op = (b != '0);
        s_err   = (b == '0);
      end
      default: s_err = 1'b1;
    endcase
  end

  // One iteration step: shift-add multiply or restoring divide on {acc, q}.
  always_comb begin
    mul_sum   = {1'b0, acc} + {1'b0, (q[0] ? b_reg : {N{1'b0}})};
    div_trial = {acc, q[N-1]} - {1'b0, b_reg};
    if (op_reg == OP_MUL) begin
      acc_nxt = mul_sum[N:1];
      q_nxt   = {mul_sum[0], q[N-1:1]};
    end else if (!div_trial[N]) begin
      acc_nxt = div_trial[N-1:0];
      q_nxt   = {q[N-2:0], 1'b1};
    end else begin
      acc_nxt = {acc[N-2:0], q[N-1]};
      q_nxt   = {q[N-2:0], 1'b0};
    end
  end

  // The final step and the result write-back share the edge where cnt hits 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_reg    <= '0;
      b_reg     <= '0;
      acc       <= '0;
      q         <= '0;
      cnt       <= '0;
      result    <= '0;
      result_hi <= '0;
      v         <= 1'b0;
      c         <= 1'b0;
      n         <= 1'b0;
      z         <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_reg <= control;
            b_reg  <= b;
            if (long_op) begin
              state <= ITER;
              cnt   <= CW'(N);
              acc   <= '0;
              q     <= a;
            end else begin
              state     <= DONE;
              result    <= s_res;
              result_hi <= '0;
              c         <= s_c;
              v         <= s_v;
              n         <= s_res[N-1];
              z         <= (s_res == '0);
              err       <= s_err;
            end
          end
        end
        ITER: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= DONE;
            c     <= 1'b0;
            err   <= 1'b0;
            case (op_reg)
              OP_MUL: begin
                result    <= q_nxt;
                result_hi <= acc_nxt;
                n         <= acc_nxt[N-1];
                z         <= ({acc_nxt, q_nxt} == '0);
                v         <= (acc_nxt != '0);
              end
              OP_DIV: begin
                result    <= q_nxt;
                result_hi <= acc_nxt;
                n         <= q_nxt[N-1];
                z         <= (q_nxt == '0);
                v         <= 1'b0;
              end
              default: begin
                result    <= acc_nxt;
                result_hi <= q_nxt;
                n         <= acc_nxt[N-1];
                z         <= (acc_nxt == '0);
                v         <= 1'b0;
              end
            endcase
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_n_bits.sv
// Self-checking bench for alu_seq_n_bits (N = 8): directed vectors, random ops
// against an arithmetic reference model, handshake and reset scenarios.
module tb_alu_seq_n_bits;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   control;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic [N-1:0] result_hi;
  logic         v, c, n, z, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq_n_bits #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .control(control), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .result_hi(result_hi),
    .v(v), .c(c), .n(n), .z(z), .err(err)
  );

  typedef struct {
    logic [N-1:0] res;
    logic [N-1:0] hi;
    logic [4:0]   fl;
    int           lat;
  } res_t;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] hi;
    logic [4:0] fl;
    logic [3:0] lat;
  } vec_t;

  // Flags packed as {v, c, n, z, err}.
  vec_t dir_vec [12] = '{
    '{4'h0, 8'h7F, 8'h01, 8'h80, 8'h00, 5'b10100, 4'd1},
    '{4'h1, 8'h05, 8'h05, 8'h00, 8'h00, 5'b01010, 4'd1},
    '{4'h1, 8'h03, 8'h05, 8'hFE, 8'h00, 5'b00100, 4'd1},
    '{4'h8, 8'h10, 8'h20, 8'h00, 8'h02, 5'b10000, 4'd9},
    '{4'h9, 8'hC8, 8'h07, 8'h1C, 8'h04, 5'b00000, 4'd9},
    '{4'h7, 8'hC8, 8'h07, 8'h04, 8'h1C, 5'b00000, 4'd9},
    '{4'h9, 8'h05, 8'h00, 8'h00, 8'h00, 5'b00011, 4'd1},
    '{4'hC, 8'h33, 8'h44, 8'h00, 8'h00, 5'b00011, 4'd1},
    '{4'h6, 8'h01, 8'h08, 8'h00, 8'h00, 5'b00010, 4'd1},
    '{4'h8, 8'hFF, 8'hFF, 8'h01, 8'hFE, 5'b10100, 4'd9},
    '{4'h7, 8'h05, 8'h00, 8'h00, 8'h00, 5'b00011, 4'd1},
    '{4'h0, 8'hFF, 8'h01, 8'h00, 8'h00, 5'b01010, 4'd1}
  };

  function automatic res_t model(input logic [3:0] op, input logic [N-1:0] av,
                                 input logic [N-1:0] bv);
    res_t e;
    int unsigned ai, bi, p;
    int sa, sb, sr;
    logic ev, ec, en, ez, ee;
    ai = av; bi = bv; p = 0;
    sa = $signed(av); sb = $signed(bv);
    e.res = '0; e.hi = '0; e.lat = 1;
    ev = 0; ec = 0; ee = 0;
    case (op)
      4'd0: begin
        e.res = N'(ai + bi); ec = (ai + bi) >= (1 << N);
        sr = sa + sb; ev = (sr > (1 << (N-1)) - 1) || (sr < -(1 << (N-1)));
      end
      4'd1: begin
        e.res = N'(ai - bi); ec = (ai >= bi);
        sr = sa - sb; ev = (sr > (1 << (N-1)) - 1) || (sr < -(1 << (N-1)));
      end
      4'd2: e.res = av & bv;
      4'd3: e.res = av | bv;
      4'd4: e.res = av ^ bv;
      4'd5: e.res = (bi >= N) ? '0 : N'(ai >> bi);
      4'd6: e.res = (bi >= N) ? '0 : N'(ai << bi);
      4'd7, 4'd9: begin
        if (bi == 0) ee = 1;
        else begin
          e.lat = N + 1;
          e.res = N'((op == 4'd9) ? ai / bi : ai % bi);
          e.hi  = N'((op == 4'd9) ? ai % bi : ai / bi);
        end
      end
      4'd8: begin
        p = ai * bi; e.res = N'(p); e.hi = N'(p >> N); e.lat = N + 1;
        ev = (e.hi != 0);
      end
      default: ee = 1;
    endcase
    if (op == 4'd8) begin
      ez = (p == 0); en = e.hi[N-1];
    end else begin
      ez = (e.res == 0); en = e.res[N-1];
    end
    e.fl = {ev, ec, en, ez, ee};
    return e;
  endfunction

  // Issues one op, scrambles the inputs after accept, returns outputs and latency.
  task automatic do_op(input logic [3:0] op, input logic [N-1:0] av,
                       input logic [N-1:0] bv, input bit release_it, output res_t o);
    @(negedge clk);
    control = op; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = N'($urandom); b = N'($urandom); control = 4'($urandom);
    o.lat = -1;
    for (int k = 1; k <= 3 * N + 4; k++) begin
      if (out_valid) begin
        o.lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    o.res = result; o.hi = result_hi; o.fl = {v, c, n, z, err};
    if (release_it) begin
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; control = '0;
    #12;
    checks++;
    if ({out_valid, result, result_hi, v, c, n, z, err} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %h required 0",
               {out_valid, result, result_hi, v, c, n, z, err});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready got %b required 1", in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed;
    res_t o;
    for (int i = 0; i < 12; i++) begin
      do_op(dir_vec[i].op, dir_vec[i].a, dir_vec[i].b, 1'b1, o);
      checks++;
      if (o.res !== dir_vec[i].res || o.hi !== dir_vec[i].hi) begin
        errors++;
        $display("[TB] FAIL dir%0d_result got %h_%h required %h_%h", i,
                 o.hi, o.res, dir_vec[i].hi, dir_vec[i].res);
      end
      checks++;
      if (o.fl !== dir_vec[i].fl) begin
        errors++;
        $display("[TB] FAIL dir%0d_flags got %b required %b", i, o.fl, dir_vec[i].fl);
      end
      checks++;
      if (o.lat != int'(dir_vec[i].lat)) begin
        errors++;
        $display("[TB] FAIL dir%0d_latency got %0d required %0d", i, o.lat, dir_vec[i].lat);
      end
    end
  endtask

  task automatic test_random;
    res_t o, e;
    logic [3:0]   op;
    logic [N-1:0] av, bv;
    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 15));
      av = N'($urandom);
      bv = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 9)) : N'($urandom);
      e = model(op, av, bv);
      do_op(op, av, bv, 1'b1, o);
      checks++;
      if (o.res !== e.res || o.hi !== e.hi || o.fl !== e.fl || o.lat != e.lat) begin
        errors++;
        $display("[TB] FAIL rand op=%h a=%h b=%h got %h_%h fl=%b lat=%0d required %h_%h fl=%b lat=%0d",
                 op, av, bv, o.hi, o.res, o.fl, o.lat, e.hi, e.res, e.fl, e.lat);
      end
    end
  endtask

  task automatic test_back_to_back;
    res_t e1, e2;
    e1 = model(4'd0, 8'h12, 8'h34);
    e2 = model(4'd4, 8'hF0, 8'h3C);
    @(negedge clk);
    control = 4'd0; a = 8'h12; b = 8'h34; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    control = 4'd4; a = 8'hF0; b = 8'h3C;
    checks++;
    if (out_valid !== 1'b1 || result !== e1.res) begin
      errors++;
      $display("[TB] FAIL b2b_first got valid=%b res=%h required valid=1 res=%h",
               out_valid, result, e1.res);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== e1.res) begin
      errors++;
      $display("[TB] FAIL b2b_gap got valid=%b ready=%b res=%h required valid=0 ready=1 res=%h",
               out_valid, in_ready, result, e1.res);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== e2.res) begin
      errors++;
      $display("[TB] FAIL b2b_second got valid=%b res=%h required valid=1 res=%h",
               out_valid, result, e2.res);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_hold;
    res_t o, e;
    e = model(4'd8, 8'hB7, 8'h5D);
    do_op(4'd8, 8'hB7, 8'h5D, 1'b0, o);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== e.res ||
          result_hi !== e.hi || {v, c, n, z, err} !== e.fl) begin
        errors++;
        $display("[TB] FAIL hold%0d got valid=%b ready=%b %h_%h fl=%b required valid=1 ready=0 %h_%h fl=%b",
                 i, out_valid, in_ready, result_hi, result, {v, c, n, z, err},
                 e.hi, e.res, e.fl);
      end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_release got valid=%b ready=%b required valid=0 ready=1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_iter;
    @(negedge clk);
    control = 4'd9; a = 8'hE1; b = 8'h03; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, result, result_hi, v, c, n, z, err} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs got %h required 0",
               {out_valid, result, result_hi, v, c, n, z, err});
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_in_ready got %b required 1", in_ready);
    end
    repeat (N + 2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_aborted got valid=%b required 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_hold();
    test_reset_mid_iter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
